// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause, updates mstatus,
// then flushes and redirects fetch; one CSR write per cycle.
module trap_ctrl #(
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        irq_i,
  input  logic [30:0] irq_code_i,
  input  logic        exc_i,
  input  logic [30:0] exc_code_i,
  input  logic        mret_i,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_i,
  input  logic        mem_busy_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        trap_active_o
);

  typedef enum logic [2:0] {
    IDLE, WAIT_MEM, W_MEPC, W_MCAUSE,
    W_MSTAT, M_MSTAT, REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ms_q, ms_d;
  logic [31:0] tvec_q, tvec_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_q, irq_d;
  logic        take;

  logic        we_d;
  logic [11:0] addr_d;
  logic [31:0] data_d;
  logic        flush_d;
  logic [31:0] npc_d;
  logic        act_d;

  logic [31:0] base;
  logic [31:0] vec_pc;
  logic [31:0] trap_ms;
  logic [31:0] ret_ms;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    ms_d    = ms_q;
    tvec_d  = tvec_q;
    epc_d   = epc_q;
    irq_d   = irq_q;
    take    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pc_valid_i) begin
          // exceptions beat mret, mret beats interrupts
          priority case (1'b1)
            exc_i: begin
              state_d = W_MEPC;
              take    = 1'b1;
              irq_d   = 1'b0;
              cause_d = {1'b0, exc_code_i};
            end
            mret_i: begin
              state_d = M_MSTAT;
              take    = 1'b1;
              irq_d   = 1'b0;
            end
            irq_i: begin
              state_d = mem_busy_i ? WAIT_MEM : W_MEPC;
              take    = 1'b1;
              irq_d   = 1'b1;
              cause_d = {1'b1, irq_code_i};
            end
            default: ;
          endcase
        end
      end
      WAIT_MEM: begin
        if (!irq_i)
          state_d = IDLE;
        else if (!mem_busy_i)
          state_d = W_MEPC;
      end
      W_MEPC:   state_d = W_MCAUSE;
      W_MCAUSE: state_d = W_MSTAT;
      W_MSTAT:  state_d = REDIRECT;
      M_MSTAT:  state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (take) begin
      pc_d   = pc_i;
      ms_d   = csr_mstatus_i;
      tvec_d = csr_mtvec_i;
      epc_d  = csr_mepc_i;
    end
  end

  always_comb begin
    base   = {tvec_d[31:2], 2'b00};
    vec_pc = base;
    if (tvec_d[1:0] == 2'b01 && irq_d)
      vec_pc = base + {cause_d[29:0], 2'b00};

    trap_ms         = ms_d;
    trap_ms[12:11]  = 2'b11;
    trap_ms[7]      = ms_d[3];
    trap_ms[3]      = 1'b0;

    ret_ms          = ms_d;
    ret_ms[3]       = ms_d[7];
    ret_ms[7]       = 1'b1;
    ret_ms[12:11]   = 2'b11;
  end

  // outputs are decoded from the next state so they register with it
  always_comb begin
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    flush_d = 1'b0;
    npc_d   = '0;
    act_d   = (state_d != IDLE);
    unique case (state_d)
      W_MEPC: begin
        we_d   = 1'b1;
        addr_d = CSR_MEPC;
        data_d = {pc_d[31:2], 2'b00};
      end
      W_MCAUSE: begin
        we_d   = 1'b1;
        addr_d = CSR_MCAUSE;
        data_d = cause_d;
      end
      W_MSTAT: begin
        we_d   = 1'b1;
        addr_d = CSR_MSTATUS;
        data_d = trap_ms;
      end
      M_MSTAT: begin
        we_d   = 1'b1;
        addr_d = CSR_MSTATUS;
        data_d = ret_ms;
      end
      REDIRECT: begin
        flush_d = 1'b1;
        npc_d   = (state_q == M_MSTAT) ? epc_d : vec_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      cause_q       <= '0;
      pc_q          <= '0;
      ms_q          <= '0;
      tvec_q        <= '0;
      epc_q         <= '0;
      irq_q         <= 1'b0;
      csr_we_o      <= 1'b0;
      csr_waddr_o   <= '0;
      csr_wdata_o   <= '0;
      stall_o       <= 1'b0;
      flush_o       <= 1'b0;
      new_pc_o      <= '0;
      trap_active_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      ms_q          <= ms_d;
      tvec_q        <= tvec_d;
      epc_q         <= epc_d;
      irq_q         <= irq_d;
      csr_we_o      <= we_d;
      csr_waddr_o   <= addr_d;
      csr_wdata_o   <= data_d;
      stall_o       <= act_d;
      flush_o       <= flush_d;
      new_pc_o      <= npc_d;
      trap_active_o <= act_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table of trap/mret
// sequences plus hand-written reset, drop and back-to-back cases.
module tb_trap_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        irq_i;
  logic [30:0] irq_code_i;
  logic        exc_i;
  logic [30:0] exc_code_i;
  logic        mret_i;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        mem_busy_i;
  logic [31:0] csr_mstatus_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        trap_active_o;

  trap_ctrl dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .irq_i         (irq_i),
    .irq_code_i    (irq_code_i),
    .exc_i         (exc_i),
    .exc_code_i    (exc_code_i),
    .mret_i        (mret_i),
    .pc_valid_i    (pc_valid_i),
    .pc_i          (pc_i),
    .mem_busy_i    (mem_busy_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .trap_active_o (trap_active_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        irq;
    logic [30:0] icode;
    logic        exc;
    logic [30:0] ecode;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] ms;
    logic [31:0] tvec;
    logic [31:0] epc;
    int          busy;
    logic [31:0] x_epc;
    logic [31:0] x_cause;
    logic [31:0] x_ms;
    logic [31:0] x_npc;
  } vec_t;

  vec_t tv[9];

  function automatic logic [79:0] pk(
    logic we, logic [11:0] a, logic [31:0] d,
    logic st, logic fl, logic [31:0] np, logic ac);
    return {we, a, d, st, fl, np, ac};
  endfunction

  function automatic logic [79:0] e_idle();
    return pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endfunction

  function automatic logic [79:0] e_wait();
    return pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
  endfunction

  function automatic logic [79:0] e_wr(logic [11:0] a, logic [31:0] d);
    return pk(1'b1, a, d, 1'b1, 1'b0, 32'h0, 1'b1);
  endfunction

  function automatic logic [79:0] e_fl(logic [31:0] np);
    return pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, np, 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [79:0] exp);
    logic [79:0] act;
    act = pk(csr_we_o, csr_waddr_o, csr_wdata_o,
             stall_o, flush_o, new_pc_o, trap_active_o);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (we,addr,data,stall,flush,npc,act)",
               nm, act, exp);
    end
  endtask

  task automatic clear_req();
    irq_i      = 1'b0;
    exc_i      = 1'b0;
    mret_i     = 1'b0;
    pc_valid_i = 1'b0;
    mem_busy_i = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          rem;
    int          nlen;
    logic [79:0] exp;
    v = tv[i];
    @(negedge wb_clk_i);
    irq_i         = v.irq;
    irq_code_i    = v.icode;
    exc_i         = v.exc;
    exc_code_i    = v.ecode;
    mret_i        = v.mret;
    pc_valid_i    = 1'b1;
    pc_i          = v.pc;
    csr_mstatus_i = v.ms;
    csr_mtvec_i   = v.tvec;
    csr_mepc_i    = v.epc;
    rem           = v.busy;
    mem_busy_i    = (rem > 0);
    nlen          = v.mret ? 3 : v.busy + 5;
    for (int k = 1; k <= nlen; k++) begin
      @(negedge wb_clk_i);
      if (v.mret) begin
        case (k)
          1:       exp = e_wr(12'h300, v.x_ms);
          2:       exp = e_fl(v.x_npc);
          default: exp = e_idle();
        endcase
      end else if (k <= v.busy) begin
        exp = e_wait();
      end else begin
        case (k - v.busy)
          1:       exp = e_wr(12'h341, v.x_epc);
          2:       exp = e_wr(12'h342, v.x_cause);
          3:       exp = e_wr(12'h300, v.x_ms);
          4:       exp = e_fl(v.x_npc);
          default: exp = e_idle();
        endcase
      end
      chk($sformatf("vec%0d_cyc%0d", i, k), exp);
      pc_valid_i = 1'b0;
      exc_i      = 1'b0;
      mret_i     = 1'b0;
      rem        = (rem > 0) ? rem - 1 : 0;
      mem_busy_i = (rem > 0);
    end
    clear_req();
  endtask

  logic [79:0] bb[10];

  initial begin
    tv[0] = '{1'b1, 31'd7, 1'b0, 31'd0, 1'b0, 32'h2004, 32'h8,
              32'h100, 32'h0, 0,
              32'h2004, 32'h8000_0007, 32'h1880, 32'h100};
    tv[1] = '{1'b1, 31'd7, 1'b0, 31'd0, 1'b0, 32'h2004, 32'h8,
              32'h101, 32'h0, 0,
              32'h2004, 32'h8000_0007, 32'h1880, 32'h11C};
    tv[2] = '{1'b0, 31'd0, 1'b1, 31'd11, 1'b0, 32'h2004, 32'h8,
              32'h101, 32'h0, 0,
              32'h2004, 32'h0000_000B, 32'h1880, 32'h100};
    tv[3] = '{1'b1, 31'd7, 1'b1, 31'd11, 1'b0, 32'h2004, 32'h8,
              32'h101, 32'h0, 0,
              32'h2004, 32'h0000_000B, 32'h1880, 32'h100};
    tv[4] = '{1'b0, 31'd0, 1'b0, 31'd0, 1'b1, 32'h2008, 32'h1880,
              32'h100, 32'h2004, 0,
              32'h0, 32'h0, 32'h1888, 32'h2004};
    tv[5] = '{1'b1, 31'd3, 1'b0, 31'd0, 1'b0, 32'h3006, 32'h0,
              32'h200, 32'h0, 3,
              32'h3004, 32'h8000_0003, 32'h1800, 32'h200};
    tv[6] = '{1'b1, 31'd7, 1'b0, 31'd0, 1'b1, 32'h10, 32'h0,
              32'h100, 32'h4000, 0,
              32'h0, 32'h0, 32'h1880, 32'h4000};
    tv[7] = '{1'b1, 31'h3FFF_FFFF, 1'b0, 31'd0, 1'b0, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'hFFFF_FF01, 32'h0, 0,
              32'hFFFF_FFFC, 32'hBFFF_FFFF, 32'hFFFF_FFF7, 32'hFFFF_FEFC};
    tv[8] = '{1'b1, 31'd7, 1'b0, 31'd0, 1'b0, 32'h2004, 32'h8,
              32'h103, 32'h0, 0,
              32'h2004, 32'h8000_0007, 32'h1880, 32'h100};

    wb_rst_i      = 1'b1;
    irq_code_i    = '0;
    exc_code_i    = '0;
    pc_i          = '0;
    csr_mstatus_i = '0;
    csr_mtvec_i   = '0;
    csr_mepc_i    = '0;
    clear_req();
    repeat (2) @(negedge wb_clk_i);
    chk("reset_state", e_idle());
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("after_reset", e_idle());

    for (int i = 0; i < 9; i++) run_vec(i);

    // requests without a valid memory-stage instruction are ignored
    @(negedge wb_clk_i);
    irq_i      = 1'b1;
    exc_i      = 1'b1;
    mret_i     = 1'b1;
    pc_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      chk($sformatf("novalid_%0d", k), e_idle());
    end
    clear_req();

    // interrupt withdrawn while waiting for the data bus
    @(negedge wb_clk_i);
    irq_i         = 1'b1;
    irq_code_i    = 31'd7;
    pc_valid_i    = 1'b1;
    mem_busy_i    = 1'b1;
    csr_mtvec_i   = 32'h100;
    csr_mstatus_i = 32'h8;
    @(negedge wb_clk_i);
    chk("drop_wait", e_wait());
    irq_i      = 1'b0;
    pc_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge wb_clk_i);
      chk($sformatf("drop_idle_%0d", k), e_idle());
      mem_busy_i = 1'b0;
    end

    // async reset between the mcause and mstatus writes
    @(negedge wb_clk_i);
    irq_i      = 1'b1;
    irq_code_i = 31'd7;
    pc_valid_i = 1'b1;
    pc_i       = 32'h2004;
    @(negedge wb_clk_i);
    chk("rst_mepc", e_wr(12'h341, 32'h2004));
    clear_req();
    @(negedge wb_clk_i);
    chk("rst_mcause", e_wr(12'h342, 32'h8000_0007));
    #2 wb_rst_i = 1'b1;
    #1 chk("rst_async", e_idle());
    @(negedge wb_clk_i);
    chk("rst_hold", e_idle());
    wb_rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge wb_clk_i);
      chk($sformatf("rst_after_%0d", k), e_idle());
    end

    // exception wins over a simultaneous irq; held irq follows
    bb[0] = e_wr(12'h341, 32'h2004);
    bb[1] = e_wr(12'h342, 32'h0000_000B);
    bb[2] = e_wr(12'h300, 32'h1880);
    bb[3] = e_fl(32'h100);
    bb[4] = e_idle();
    bb[5] = e_wr(12'h341, 32'h2004);
    bb[6] = e_wr(12'h342, 32'h8000_0007);
    bb[7] = e_wr(12'h300, 32'h1800);
    bb[8] = e_fl(32'h100);
    bb[9] = e_idle();
    @(negedge wb_clk_i);
    exc_i         = 1'b1;
    exc_code_i    = 31'd11;
    irq_i         = 1'b1;
    irq_code_i    = 31'd7;
    pc_valid_i    = 1'b1;
    pc_i          = 32'h2004;
    csr_mstatus_i = 32'h8;
    csr_mtvec_i   = 32'h100;
    for (int k = 0; k < 10; k++) begin
      @(negedge wb_clk_i);
      chk($sformatf("b2b_cyc%0d", k + 1), bb[k]);
      exc_i = 1'b0;
      if (k == 2) csr_mstatus_i = 32'h1880;
      if (k == 7) begin
        irq_i      = 1'b0;
        pc_valid_i = 1'b0;
      end
    end
    clear_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
